// File: rtl/store_sequencer_pkg.sv
// Package for the store sequencer: FSM state type, size codes and a helper
// that turns a size code into a right-aligned 4-bit byte-enable pattern.
package store_sequencer_pkg;

`include "store_defs.vh"

    typedef enum logic [1:0] {
        IDLE = `STORE_IDLE,
        WR1  = `STORE_WR1,
        WR2  = `STORE_WR2
    } state_t;

    localparam logic [1:0] SZ_SB = `STORE_SB;
    localparam logic [1:0] SZ_SH = `STORE_SH;
    localparam logic [1:0] SZ_SW = `STORE_SW;

    // Byte enables for n bytes starting at lane 0 (n = 1, 2 or 4).
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_SB:   size_mask = 4'b0001;
            SZ_SH:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/store_sequencer_if.sv
// Store sequencer bus bundle: core-side store request channel plus the
// word-wide memory write channel.
//   slave  : the sequencer's view (accepts st_*, drives mem_*, gets mem_ack)
//   master : the core/memory view (drives st_* and mem_ack)
interface store_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;
    logic              st_ready;
    logic              st_done;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;

    modport slave (
        input  st_req, st_addr, st_data, st_size, mem_ack,
        output st_ready, st_done, busy, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output st_req, st_addr, st_data, st_size, mem_ack,
        input  st_ready, st_done, busy, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/store_defs.vh
// Shared encodings for the store sequencer.
//   State codes: IDLE, WR1 (first/only bus beat), WR2 (second beat of a split store).
//   Size codes:  SB (byte), SH (halfword), SW (word); code 2'b11 is handled as SW.
`ifndef STORE_DEFS_VH
`define STORE_DEFS_VH

`define STORE_IDLE 2'd0
`define STORE_WR1  2'd1
`define STORE_WR2  2'd2

`define STORE_SB   2'b00
`define STORE_SH   2'b01
`define STORE_SW   2'b10

`endif

// File: rtl/store_lane_gen.sv
// Combinational byte-lane placement for a store.
//   size   : store size code
//   offset : byte offset within the word (addr[1:0])
//   data   : store data, low bytes significant
//   mask8  : byte enables over two consecutive words (bits 7:4 = next word)
//   data64 : lane-positioned data over two consecutive words
module store_lane_gen
    import store_sequencer_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [7:0]  mask8,
    output logic [63:0] data64
);
    logic [3:0]  nmask;
    logic [31:0] data_masked;
    logic [5:0]  shamt;

    assign nmask = size_mask(size);
    assign shamt = {1'b0, offset, 3'b000};

    // Clear bytes beyond the store size so they cannot leak onto the bus.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign data_masked[gi*8 +: 8] = nmask[gi] ? data[gi*8 +: 8] : 8'h00;
    end

    assign mask8  = {4'b0000, nmask} << offset;
    assign data64 = {32'h0, data_masked} << shamt;
endmodule

// File: rtl/store_sequencer.sv
// Store sequencer: accepts one core store at a time and issues it as one or
// two word-aligned bus write beats (two when the bytes cross a word boundary).
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : store request / memory write bundle (slave view)
// All mem_* outputs and st_done are registered; st_ready/busy decode the
// state register directly.
module store_sequencer
    import store_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    store_sequencer_if.slave   bus
);
    state_t            state_reg;
    logic [3:0]        hi_strb_reg;
    logic [31:0]       hi_data_reg;
    logic              done_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;

    logic [7:0]        mask8;
    logic [63:0]       data64;

    // Lane placement runs on the incoming request so the first beat can be
    // registered at the accepting edge; the second-beat half is kept aside.
    store_lane_gen u_lane_gen (
        .size   (bus.st_size),
        .offset (bus.st_addr[1:0]),
        .data   (bus.st_data),
        .mask8  (mask8),
        .data64 (data64)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            hi_strb_reg <= 4'h0;
            hi_data_reg <= 32'h0;
            done_reg    <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= 32'h0;
            wstrb_reg   <= 4'h0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.st_req) begin
                        state_reg   <= WR1;
                        we_reg      <= 1'b1;
                        addr_reg    <= {bus.st_addr[ADDR_W-1:2], 2'b00};
                        wstrb_reg   <= mask8[3:0];
                        wdata_reg   <= data64[31:0];
                        hi_strb_reg <= mask8[7:4];
                        hi_data_reg <= data64[63:32];
                    end
                end
                WR1: begin
                    if (bus.mem_ack) begin
                        if (hi_strb_reg != 4'h0) begin
                            state_reg <= WR2;
                            addr_reg  <= addr_reg + ADDR_W'(4);
                            wstrb_reg <= hi_strb_reg;
                            wdata_reg <= hi_data_reg;
                        end else begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                            we_reg    <= 1'b0;
                            addr_reg  <= '0;
                            wstrb_reg <= 4'h0;
                            wdata_reg <= 32'h0;
                        end
                    end
                end
                WR2: begin
                    if (bus.mem_ack) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        we_reg    <= 1'b0;
                        addr_reg  <= '0;
                        wstrb_reg <= 4'h0;
                        wdata_reg <= 32'h0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    we_reg    <= 1'b0;
                    addr_reg  <= '0;
                    wstrb_reg <= 4'h0;
                    wdata_reg <= 32'h0;
                end
            endcase
        end
    end

    assign bus.st_ready  = (state_reg == IDLE);
    assign bus.busy      = (state_reg == WR1) || (state_reg == WR2);
    assign bus.st_done   = done_reg;
    assign bus.mem_we    = we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.mem_wstrb = wstrb_reg;
endmodule

// File: tb/tb_store_sequencer.sv
// Directed testbench for store_sequencer: hand-computed bus beats for the
// listed store cases, a reset abort mid-store and a back-to-back store pair.
module tb_store_sequencer;
    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;

    store_sequencer_if #(.ADDR_W(32)) bus ();

    store_sequencer #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
        chk({tag, ".we"},    64'(bus.mem_we),    64'd1);
        chk({tag, ".busy"},  64'(bus.busy),      64'd1);
        chk({tag, ".rdy"},   64'(bus.st_ready),  64'd0);
        chk({tag, ".addr"},  64'(bus.mem_addr),  64'(a));
        chk({tag, ".strb"},  64'(bus.mem_wstrb), 64'(s));
        chk({tag, ".wdata"}, 64'(bus.mem_wdata), 64'(d));
        chk({tag, ".done"},  64'(bus.st_done),   64'd0);
    endtask

    task automatic chk_idle(input string tag, input logic done_exp);
        chk({tag, ".rdy"},   64'(bus.st_ready),  64'd1);
        chk({tag, ".busy"},  64'(bus.busy),      64'd0);
        chk({tag, ".done"},  64'(bus.st_done),   64'(done_exp));
        chk({tag, ".we"},    64'(bus.mem_we),    64'd0);
        chk({tag, ".strb"},  64'(bus.mem_wstrb), 64'd0);
        chk({tag, ".addr"},  64'(bus.mem_addr),  64'd0);
        chk({tag, ".wdata"}, 64'(bus.mem_wdata), 64'd0);
    endtask

    // Drives one store; inputs change and outputs are sampled on negedges.
    task automatic run_store(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] data, input int waits, input int nbeats,
                             input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
                             input logic [31:0] a2, input logic [3:0] s2, input logic [31:0] d2);
        @(negedge clk);
        chk({tag, ".pre_rdy"}, 64'(bus.st_ready), 64'd1);
        bus.st_req  = 1'b1;
        bus.st_size = sz;
        bus.st_addr = addr;
        bus.st_data = data;
        @(negedge clk);
        bus.st_req  = 1'b0;
        bus.st_data = 32'hFFFF_FFFF;
        for (int w = 0; w < waits; w++) begin
            chk_beat({tag, ".b1w"}, a1, s1, d1);
            @(negedge clk);
        end
        chk_beat({tag, ".b1"}, a1, s1, d1);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        if (nbeats == 2) begin
            chk_beat({tag, ".b2"}, a2, s2, d2);
            bus.mem_ack = 1'b1;
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        chk_idle({tag, ".end"}, 1'b1);
        @(negedge clk);
        chk_idle({tag, ".post"}, 1'b0);
        $display("store %s size=%0d addr=%h data=%h beats=%0d", tag, sz, addr, data, nbeats);
    endtask

    initial begin
        vec_cnt     = 0;
        err_cnt     = 0;
        reset       = 1'b1;
        bus.st_req  = 1'b0;
        bus.st_addr = 32'h0;
        bus.st_data = 32'h0;
        bus.st_size = 2'b00;
        bus.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_idle("reset", 1'b0);

        run_store("sw_100", 2'b10, 32'h100, 32'hDEADBEEF, 2, 1,
                  32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0);
        run_store("sb_103", 2'b00, 32'h103, 32'h123456AB, 0, 1,
                  32'h100, 4'b1000, 32'hAB000000, 32'h0, 4'h0, 32'h0);
        run_store("sh_103", 2'b01, 32'h103, 32'h00001234, 1, 2,
                  32'h100, 4'b1000, 32'h34000000, 32'h104, 4'b0001, 32'h00000012);
        run_store("sw_102", 2'b10, 32'h102, 32'hAABBCCDD, 0, 2,
                  32'h100, 4'b1100, 32'hCCDD0000, 32'h104, 4'b0011, 32'h0000AABB);
        run_store("s11_wrap", 2'b11, 32'hFFFFFFFE, 32'h11223344, 0, 2,
                  32'hFFFFFFFC, 4'b1100, 32'h33440000, 32'h00000000, 4'b0011, 32'h00001122);
        run_store("sh_102", 2'b01, 32'h102, 32'h0000BEEF, 0, 1,
                  32'h100, 4'b1100, 32'hBEEF0000, 32'h0, 4'h0, 32'h0);

        // Reset while waiting in WR2: store is abandoned, no done pulse.
        @(negedge clk);
        bus.st_req  = 1'b1;
        bus.st_size = 2'b01;
        bus.st_addr = 32'h103;
        bus.st_data = 32'h00001234;
        @(negedge clk);
        bus.st_req  = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk_beat("rst.wr2", 32'h104, 4'b0001, 32'h00000012);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("rst.after", 1'b0);
        @(negedge clk);
        chk_idle("rst.after2", 1'b0);
        $display("store reset-abort in WR2");

        // Back-to-back: request held through the first done cycle.
        bus.st_req  = 1'b1;
        bus.st_size = 2'b10;
        bus.st_addr = 32'h200;
        bus.st_data = 32'h01020304;
        @(negedge clk);
        chk_beat("b2b.first", 32'h200, 4'b1111, 32'h01020304);
        bus.st_addr = 32'h204;
        bus.st_data = 32'h55667788;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk({"b2b.done"}, 64'(bus.st_done),  64'd1);
        chk({"b2b.rdy"},  64'(bus.st_ready), 64'd1);
        @(negedge clk);
        bus.st_req = 1'b0;
        chk_beat("b2b.second", 32'h204, 4'b1111, 32'h55667788);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk_idle("b2b.end", 1'b1);
        $display("store back-to-back sw 0x200 / 0x204");

        // Ack while idle must not disturb anything.
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk_idle("idle_ack", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/store_sequencer.md
STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001: Parameter ADDR_W, default 32, byte-address width of the store and bus address ports.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: st_req  input  1  core store request, held until accepted.
REQ-005: st_addr  input  ADDR_W  byte address of the store.
REQ-006: st_data  input  32  store data; low bytes used per size.
REQ-007: st_size  input  2  00 sb, 01 sh, 10 sw, 11 treated as sw.
REQ-008: st_ready  output  1  sequencer idle and able to accept a request.
REQ-009: st_done  output  1  one-cycle pulse when the final bus beat of a store is acknowledged.
REQ-010: busy  output  1  store in flight, used as a pipeline stall.
REQ-011: mem_we  output  1  bus write valid.
REQ-012: mem_addr  output  ADDR_W  word-aligned bus address, with bits [1:0] always 0.
REQ-013: mem_wdata  output  32  lane-positioned write data.
REQ-014: mem_wstrb  output  4  byte strobes, where bit i enables byte lane i.
REQ-015: mem_ack  input  1  bus accepts the current beat in this cycle.

Function
REQ-016: The FSM SHALL have states IDLE, WR1 and WR2.
REQ-017: A request is accepted on an edge where st_req=1 and the state is IDLE.
  - Acceptance latches st_addr, st_data and st_size.
  - The state moves to WR1.
  - Inputs are ignored at all other times.
REQ-018: st_ready SHALL be 1 exactly when the state is IDLE; busy SHALL be 1 exactly when the state is WR1 or WR2.
REQ-019: Byte count n is 1 (sb), 2 (sh), or 4 (sw and 11), and byte offset is o=addr[1:0].
  - mask8 = ((1<<n)-1)<<o over 8 bits.
  - data64 = zero-extended low n bytes of the data, shifted left by 8*o over 64 bits.
REQ-020: In WR1, mem_we=1, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_wstrb=mask8[3:0] and mem_wdata=data64[31:0].
REQ-021: In WR2, mem_we=1, mem_addr=(WR1 address + 4) modulo 2^ADDR_W, mem_wstrb=mask8[7:4] and mem_wdata=data64[63:32].
REQ-022: A store is a split store when mask8[7:4] is nonzero.
  - WR1 with mem_ack=1 goes to WR2 for a split store.
  - WR1 with mem_ack=1 goes to IDLE otherwise.
  - WR2 with mem_ack=1 goes to IDLE.
REQ-023: With mem_ack=0, the state and all mem_* outputs SHALL hold unchanged, with no limit on the number of wait cycles.
REQ-024: st_done SHALL be 1 in the cycle after the edge that sampled the final mem_ack, and 0 otherwise.
REQ-025: st_done and st_ready may be 1 together, and a new request may be accepted in that cycle (back-to-back stores, no bubble).
REQ-026: mem_ack SHALL be ignored in IDLE.
REQ-027: mem_* outputs SHALL depend only on registered state, with no combinational path from st_* or mem_ack.
REQ-028: Outside WR1 and WR2, mem_we=0, mem_wstrb=0, mem_addr=0 and mem_wdata=0.
REQ-029: Minimum latency is 1 cycle from acceptance to mem_we=1, and a store takes 1 or 2 bus beats.

Reset
REQ-030: reset=1 at an edge SHALL force IDLE from any state, including mid-beat, with no completion of the in-flight store.
REQ-031: In the cycle after reset, the outputs SHALL be:
  - st_ready=1;
  - st_done=0, busy=0 and mem_we=0;
  - mem_wstrb=0, mem_addr=0 and mem_wdata=0.
REQ-032: reset SHALL take priority over a simultaneous st_req or mem_ack.

Structure
REQ-033: A shared defines include store_defs.vh SHALL hold:
  - the state encodings IDLE, WR1 and WR2;
  - the size codes SB, SH and SW.
REQ-034: The purely combinational mask8 and data64 generation SHALL be one sub-module, store_lane_gen.
  - Inputs: size, offset, data.
  - Outputs: mask8, data64.
  - The FSM, holding registers and output muxing stay in store_sequencer.

Verification
REQ-035: sw addr 0x100 data 0xDEADBEEF, ack after 2 wait cycles -> single beat: addr 0x100, strb 1111, wdata 0xDEADBEEF; st_done 1 cycle after ack.
REQ-036: sb addr 0x103 data 0x123456AB -> single beat: addr 0x100, strb 1000, wdata 0xAB000000.
REQ-037: sh addr 0x103 data 0x00001234 -> two beats:
  - beat 1: addr 0x100, strb 1000, wdata 0x34000000;
  - beat 2: addr 0x104, strb 0001, wdata 0x00000012.
REQ-038: sw addr 0x102 data 0xAABBCCDD -> two beats:
  - beat 1: addr 0x100, strb 1100, wdata 0xCCDD0000;
  - beat 2: addr 0x104, strb 0011, wdata 0x0000AABB.
REQ-039: size 11 addr 0xFFFFFFFE data 0x11223344 -> treated as sw, two beats:
  - beat 1: addr 0xFFFFFFFC, strb 1100, wdata 0x33440000;
  - beat 2 wraps: addr 0x00000000, strb 0011, wdata 0x00001122.
REQ-040: Reset asserted during WR2 with mem_ack=0 -> next cycle mem_we=0, st_ready=1, no st_done pulse.
  - Then a back-to-back sw, with a second st_req held through the first st_done cycle -> accepted with no idle bubble.
